goodness_tracker: RTL and testbench

GOODNESS_TRACKER -- requirements
Module: goodness_tracker

---
 rtl/goodness_pkg.sv | 24 ++
 rtl/goodness_beat_reduce.sv | 73 +++++++
 rtl/goodness_tracker.sv | 144 ++++++++++++++
 tb/tb_goodness_tracker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/goodness_pkg.sv
// Shared definitions for the goodness tracker.
//
// Holds the mode encoding and the width helpers used by both the per-core
// beat reducer and the top-level accumulator. The widths are given as
// functions because they depend on the instantiating module's parameters.
package goodness_pkg;

  // Goodness mode: plain ReLU sum, or sum of squared ReLU outputs.
  typedef enum logic {
    MODE_RELU    = 1'b0,
    MODE_RELU_SQ = 1'b1
  } mode_e;

  // Width of one neuron term: (M-1) magnitude bits, squared.
  function automatic int term_width(input int mem_w);
    return 2 * (mem_w - 1);
  endfunction

  // Width of the sum of P terms from one beat.
  function automatic int beat_sum_width(input int mem_w, input int par);
    return 2 * (mem_w - 1) + $clog2(par);
  endfunction

endpackage

// File: rtl/goodness_beat_reduce.sv
// Per-core beat reducer (stage S1).
//
// Applies ReLU (and optionally squaring) to P signed membrane values and
// registers their sum together with the beat's valid/last qualifiers.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        synchronous clear; drops any captured beat
//   valid, last  beat qualifiers (last is only honoured with valid)
//   mode         0 = ReLU, 1 = ReLU squared; sampled with the beat
//   mem          P neurons of M bits, neuron n at bit offset n*M
//   s1_valid     registered beat valid
//   s1_last      registered last flag (already qualified by valid)
//   s1_sum       registered beat sum
module goodness_beat_reduce
  import goodness_pkg::*;
#(
  parameter  int P     = 8,
  parameter  int M     = 13,
  localparam int SUM_W = beat_sum_width(M, P)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic             last,
  input  logic             mode,
  input  logic [P*M-1:0]   mem,
  output logic             s1_valid,
  output logic             s1_last,
  output logic [SUM_W-1:0] s1_sum
);

  localparam int TERM_W = term_width(M);

  logic [SUM_W-1:0]  sum_d;
  logic [M-2:0]      relu;
  logic [TERM_W-1:0] term;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    sum_d = '0;
    relu  = '0;
    term  = '0;
    for (int n = 0; n < P; n++) begin
      // Negative membrane (sign bit set) contributes nothing.
      relu = mem[n*M + M - 1] ? '0 : mem[n*M +: M-1];
      if (mode == MODE_RELU_SQ) term = TERM_W'(relu) * TERM_W'(relu);
      else                      term = TERM_W'(relu);
      sum_d = sum_d + SUM_W'(term);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= valid;
      s1_last  <= valid & last;
      if (valid) s1_sum <= sum_d;
    end
  end

endmodule

// File: rtl/goodness_tracker.sv
// Goodness tracker: per-core sample goodness and exponential moving average.
//
// Each core streams beats of P membrane values. Beat sums (S1) are
// accumulated with saturation into a per-sample total (S2); on the last
// beat the total is published with a threshold flag, and one cycle later
// the moving average is updated and done pulses.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   core_valid    beat valid per core
//   core_last     final beat of a sample, qualified by core_valid
//   core_clear    synchronous per-core clear, overrides all core activity
//   core_mem_bus  core c neuron n at bit offset (c*P+n)*M
//   mode          0 = ReLU sum, 1 = ReLU squared sum
//   avg_shift     EMA shift s
//   theta         goodness threshold
//   sample_bus    last completed sample goodness per core
//   avg_bus       moving-average goodness per core
//   done          one-cycle pulse per average update
//   above_theta   sample goodness > theta, registered with the sample
module goodness_tracker
  import goodness_pkg::*;
#(
  parameter int CORE_NUM            = 4,
  parameter int POST_NEUR_PARALLEL  = 8,
  parameter int POST_NEUR_MEM_WIDTH = 13,
  parameter int GOODNESS_WIDTH      = 24
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic [CORE_NUM-1:0]                                     core_valid,
  input  logic [CORE_NUM-1:0]                                     core_last,
  input  logic [CORE_NUM-1:0]                                     core_clear,
  input  logic [CORE_NUM*POST_NEUR_PARALLEL*POST_NEUR_MEM_WIDTH-1:0] core_mem_bus,
  input  logic                                                    mode,
  input  logic [3:0]                                              avg_shift,
  input  logic [GOODNESS_WIDTH-1:0]                               theta,
  output logic [CORE_NUM*GOODNESS_WIDTH-1:0]                      sample_bus,
  output logic [CORE_NUM*GOODNESS_WIDTH-1:0]                      avg_bus,
  output logic [CORE_NUM-1:0]                                     done,
  output logic [CORE_NUM-1:0]                                     above_theta
);

  localparam int P     = POST_NEUR_PARALLEL;
  localparam int M     = POST_NEUR_MEM_WIDTH;
  localparam int G     = GOODNESS_WIDTH;
  localparam int SUM_W = beat_sum_width(M, P);
  // One extra bit over the wider operand so the add can never wrap.
  localparam int ACC_W = ((G > SUM_W) ? G : SUM_W) + 1;
  localparam logic [G-1:0] G_MAX = '1;

  for (genvar c = 0; c < CORE_NUM; c++) begin : g_core
    logic             s1_valid;
    logic             s1_last;
    logic [SUM_W-1:0] s1_sum;

    logic             s2_valid;   // a sample completed last edge; update avg
    logic             seeded;
    logic             done_q;
    logic             above_q;
    logic [G-1:0]     acc_q;
    logic [G-1:0]     sample_q;
    logic [G-1:0]     avg_q;

    logic [ACC_W-1:0] acc_sum;
    logic [G-1:0]     acc_sat;
    logic [G:0]       avg_keep;
    logic [G:0]       avg_sum;
    logic [G-1:0]     avg_next;

    goodness_beat_reduce #(
      .P (P),
      .M (M)
    ) u_reduce (
      .clk      (clk),
      .rst      (rst),
      .clear    (core_clear[c]),
      .valid    (core_valid[c]),
      .last     (core_last[c]),
      .mode     (mode),
      .mem      (core_mem_bus[c*P*M +: P*M]),
      .s1_valid (s1_valid),
      .s1_last  (s1_last),
      .s1_sum   (s1_sum)
    );

    assign acc_sum = ACC_W'(acc_q) + ACC_W'(s1_sum);
    assign acc_sat = (acc_sum > ACC_W'(G_MAX)) ? G_MAX : acc_sum[G-1:0];

    // avg - (avg>>s) never underflows; only the final add can exceed G bits.
    // With s = 0 this collapses to the new sample.
    assign avg_keep = {1'b0, avg_q} - {1'b0, avg_q >> avg_shift};
    assign avg_sum  = avg_keep + {1'b0, sample_q >> avg_shift};
    assign avg_next = avg_sum[G] ? G_MAX : avg_sum[G-1:0];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid <= 1'b0;
        seeded   <= 1'b0;
        done_q   <= 1'b0;
        above_q  <= 1'b0;
        acc_q    <= '0;
        sample_q <= '0;
        avg_q    <= '0;
      end else if (core_clear[c]) begin
        s2_valid <= 1'b0;
        seeded   <= 1'b0;
        done_q   <= 1'b0;
        above_q  <= 1'b0;
        acc_q    <= '0;
        sample_q <= '0;
        avg_q    <= '0;
      end else begin
        done_q   <= s2_valid;
        s2_valid <= s1_valid & s1_last;

        if (s2_valid) begin
          if (!seeded) begin
            avg_q  <= sample_q;
            seeded <= 1'b1;
          end else begin
            avg_q  <= avg_next;
          end
        end

        if (s1_valid) begin
          if (s1_last) begin
            sample_q <= acc_sat;
            above_q  <= (acc_sat > theta);
            acc_q    <= '0;
          end else begin
            acc_q    <= acc_sat;
          end
        end
      end
    end

    assign sample_bus[c*G +: G] = sample_q;
    assign avg_bus[c*G +: G]    = avg_q;
    assign done[c]              = done_q;
    assign above_theta[c]       = above_q;
  end

endmodule

// File: tb/tb_goodness_tracker.sv
// Self-checking bench for goodness_tracker: directed scenarios followed by
// randomized samples, all compared against an arithmetic reference model.
module tb_goodness_tracker;

  localparam int CN = 4;
  localparam int P  = 8;
  localparam int M  = 13;
  localparam int G  = 24;
  localparam longint GMAX = (longint'(1) << G) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [CN-1:0]         core_valid;
  logic [CN-1:0]         core_last;
  logic [CN-1:0]         core_clear;
  logic [CN*P*M-1:0]     core_mem_bus;
  logic                  mode;
  logic [3:0]            avg_shift;
  logic [G-1:0]          theta;
  logic [CN*G-1:0]       sample_bus;
  logic [CN*G-1:0]       avg_bus;
  logic [CN-1:0]         done;
  logic [CN-1:0]         above_theta;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state, one entry per core.
  int     nv [P];
  longint m_acc    [CN];
  longint m_sample [CN];
  longint m_avg    [CN];
  bit     m_seeded [CN];
  bit     m_above  [CN];

  goodness_tracker #(
    .CORE_NUM            (CN),
    .POST_NEUR_PARALLEL  (P),
    .POST_NEUR_MEM_WIDTH (M),
    .GOODNESS_WIDTH      (G)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .core_valid   (core_valid),
    .core_last    (core_last),
    .core_clear   (core_clear),
    .core_mem_bus (core_mem_bus),
    .mode         (mode),
    .avg_shift    (avg_shift),
    .theta        (theta),
    .sample_bus   (sample_bus),
    .avg_bus      (avg_bus),
    .done         (done),
    .above_theta  (above_theta)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [G-1:0] sample_of(input int c);
    return sample_bus[c*G +: G];
  endfunction

  function automatic logic [G-1:0] avg_of(input int c);
    return avg_bus[c*G +: G];
  endfunction

  // One neuron's contribution straight from the rules: negatives give 0.
  function automatic longint term_of(input int v, input bit md);
    if (v < 0) return 0;
    return md ? longint'(v) * longint'(v) : longint'(v);
  endfunction

  function automatic longint ema(input longint a, input longint s, input int sh);
    longint v;
    v = a - (a >> sh) + (s >> sh);
    return (v > GMAX) ? GMAX : v;
  endfunction

  task automatic model_clear(input int c);
    m_acc[c] = 0; m_sample[c] = 0; m_avg[c] = 0;
    m_seeded[c] = 0; m_above[c] = 0;
  endtask

  // Drive nv[] as one beat on core c, advance through the capture edge and
  // fold the beat into the model.
  task automatic send_beat(input int c, input bit last);
    longint tot;
    logic [31:0] w;
    tot = 0;
    for (int n = 0; n < P; n++) begin
      w = nv[n];
      core_mem_bus[(c*P+n)*M +: M] = w[M-1:0];
      tot += term_of(nv[n], mode);
    end
    core_valid = CN'(1) << c;
    core_last  = last ? (CN'(1) << c) : '0;
    m_acc[c] = (m_acc[c] + tot > GMAX) ? GMAX : m_acc[c] + tot;
    if (last) begin
      m_sample[c] = m_acc[c];
      m_above[c]  = (m_sample[c] > longint'(theta));
      m_acc[c]    = 0;
      if (!m_seeded[c]) begin
        m_avg[c] = m_sample[c];
        m_seeded[c] = 1;
      end else begin
        m_avg[c] = ema(m_avg[c], m_sample[c], int'(avg_shift));
      end
    end
    step();
    core_valid = '0;
    core_last  = '0;
  endtask

  // Called right after the last beat's capture edge: checks sample/flag one
  // edge later and avg plus the done pulse the edge after that.
  task automatic finish_check(input int c, input string tag);
    step();
    check({tag, "_sample"}, sample_of(c), m_sample[c]);
    check({tag, "_above"},  above_theta[c], m_above[c]);
    check({tag, "_nodone"}, done, '0);
    step();
    check({tag, "_avg"},    avg_of(c), m_avg[c]);
    check({tag, "_done"},   done, CN'(1) << c);
    step();
    check({tag, "_done_end"}, done, '0);
  endtask

  task automatic fill(input int v);
    for (int n = 0; n < P; n++) nv[n] = v;
  endtask

  initial begin
    longint avg_mid;
    int     c, nb, mag;

    rst = 1'b1;
    core_valid = '0; core_last = '0; core_clear = '0; core_mem_bus = '0;
    mode = 1'b0; avg_shift = 4'd4; theta = G'(1000);
    for (int i = 0; i < CN; i++) model_clear(i);
    step(); step();
    check("rst_sample", sample_bus, '0);
    check("rst_avg",    avg_bus, '0);
    check("rst_done",   done, '0);
    check("rst_above",  above_theta, '0);
    rst = 1'b0;

    // Seed on core 0: 8 x 100 = 800.
    fill(100);
    send_beat(0, 1'b1);
    finish_check(0, "seed");
    check("seed_800",   sample_of(0), 800);
    check("seed_avg",   avg_of(0), 800);
    check("seed_iso",   avg_of(1), 0);

    // Second sample 1600 with s = 4: 800 - 50 + 100.
    fill(200);
    send_beat(0, 1'b1);
    finish_check(0, "ema");
    check("ema_850",    avg_of(0), 850);
    check("ema_above",  above_theta[0], 1'b1);

    // Squared mode, mixed signs on core 1; mode flips right after capture.
    mode = 1'b1;
    for (int n = 0; n < P; n++) nv[n] = (n % 2 == 0) ? 10 : -5;
    send_beat(1, 1'b1);
    mode = 1'b0;
    finish_check(1, "sq");
    check("sq_400",     sample_of(1), 400);

    // Saturation: three beats of 4095^2 on core 3.
    mode = 1'b1;
    fill(4095);
    send_beat(3, 1'b0);
    send_beat(3, 1'b0);
    send_beat(3, 1'b1);
    finish_check(3, "sat");
    check("sat_max",    sample_of(3), GMAX);

    // Shift of zero makes avg track the sample exactly.
    mode = 1'b0; avg_shift = 4'd0;
    fill(20);
    send_beat(3, 1'b1);
    finish_check(3, "s0");
    check("s0_avg",     avg_of(3), 160);
    avg_shift = 4'd4;

    // Clear between the first and last beat of a sample on core 2.
    fill(100);
    send_beat(2, 1'b1);
    finish_check(2, "pre_clr");
    fill(50);
    send_beat(2, 1'b0);
    core_clear = CN'(1) << 2;
    step();
    core_clear = '0;
    model_clear(2);
    check("clr_avg",    avg_of(2), 0);
    check("clr_sample", sample_of(2), 0);
    for (int i = 0; i < 3; i++) begin
      check("clr_nodone", done, '0);
      step();
    end
    fill(20);
    send_beat(2, 1'b1);
    finish_check(2, "reseed");
    check("reseed_160", avg_of(2), 160);

    // Clear while a completed sample is still in flight.
    fill(30);
    send_beat(2, 1'b1);
    core_clear = CN'(1) << 2;
    step();
    core_clear = '0;
    model_clear(2);
    check("inflt_sample", sample_of(2), 0);
    for (int i = 0; i < 3; i++) begin
      check("inflt_nodone", done, '0);
      step();
    end
    check("inflt_avg",  avg_of(2), 0);

    // Back-to-back single-beat samples on core 1.
    fill(10);
    send_beat(1, 1'b1);
    avg_mid = m_avg[1];
    fill(60);
    send_beat(1, 1'b1);
    check("b2b_s1",     sample_of(1), 80);
    step();
    check("b2b_s2",     sample_of(1), m_sample[1]);
    check("b2b_avg1",   avg_of(1), avg_mid);
    check("b2b_done1",  done, CN'(1) << 1);
    step();
    check("b2b_avg2",   avg_of(1), m_avg[1]);
    check("b2b_done2",  done, CN'(1) << 1);
    step();
    check("b2b_done3",  done, '0);

    // Reset in the middle of in-flight last beats on every core.
    fill(77);
    core_valid = '1; core_last = '1;
    for (int i = 0; i < CN; i++)
      for (int n = 0; n < P; n++) core_mem_bus[(i*P+n)*M +: M] = M'(77);
    step();
    core_valid = '0; core_last = '0;
    rst = 1'b1;
    #1;
    check("mid_rst_sample", sample_bus, '0);
    check("mid_rst_avg",    avg_bus, '0);
    check("mid_rst_done",   done, '0);
    check("mid_rst_above",  above_theta, '0);
    step();
    rst = 1'b0;
    for (int i = 0; i < CN; i++) model_clear(i);
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_nodone", done, '0);
      check("post_rst_sample", sample_bus, '0);
    end

    // Randomized samples against the model.
    for (int r = 0; r < 24; r++) begin
      c   = int'($urandom_range(0, CN-1));
      nb  = int'($urandom_range(1, 3));
      mag = (r % 2 == 0) ? 60 : 4095;
      mode      = 1'($urandom_range(0, 1));
      avg_shift = 4'($urandom_range(0, 15));
      theta     = G'($urandom_range(0, 200000));
      for (int b = 0; b < nb; b++) begin
        for (int n = 0; n < P; n++) nv[n] = int'($urandom_range(0, 2*mag)) - mag;
        send_beat(c, b == nb - 1);
      end
      finish_check(c, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
